// File: rtl/ram_pkg.sv
// Shared definitions for the banked RAM: sweep FSM encoding and the legal
// range of the read pipeline depth.
package ram_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 3;

endpackage

// File: rtl/ram_lane.sv
// One byte-lane storage array: single write port, asynchronous read port.
// Bypass, pipelining and clearing are handled by the enclosing ram_banked.
module ram_lane #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ram_banked.sv
// Lane-masked word RAM with write-first read bypass, a 1..3 cycle read
// pipeline and a zero-fill sweep that runs after reset or on request.
module ram_banked
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_LANES      = 4,
  parameter int ADDR_WIDTH     = 12,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             read_req,
  input  logic [ADDR_WIDTH-1:0]            read_addr,
  output logic [NUM_LANES*DATA_WIDTH-1:0]  read_data,
  output logic                             read_valid,
  input  logic                             write_req,
  input  logic [ADDR_WIDTH-1:0]            write_addr,
  input  logic [NUM_LANES*DATA_WIDTH-1:0]  write_data,
  input  logic [NUM_LANES-1:0]             write_lane_en,
  input  logic                             clear_req,
  output logic                             busy
);

  localparam int W = NUM_LANES * DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

  generate
    if (READ_LATENCY < READ_LATENCY_MIN || READ_LATENCY > READ_LATENCY_MAX) begin : g_bad_latency
      $error("ram_banked: READ_LATENCY must lie in 1..3");
    end
  endgenerate

  // Overlay the enabled lanes of a write onto the stored word.
  function automatic logic [W-1:0] merge_lanes(input logic [W-1:0]         old_word,
                                               input logic [W-1:0]         new_word,
                                               input logic [NUM_LANES-1:0] lane_en);
    logic [W-1:0] result;
    result = old_word;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (lane_en[k]) begin
        result[k*DATA_WIDTH +: DATA_WIDTH] = new_word[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    return result;
  endfunction

  state_t                  state;
  state_t                  state_next;
  logic [ADDR_WIDTH-1:0]   sweep_addr;

  logic                    rd_accept;
  logic                    wr_accept;
  logic                    wr_hit;
  logic [NUM_LANES-1:0]    lane_we;
  logic [ADDR_WIDTH-1:0]   lane_waddr;
  logic [W-1:0]            lane_wdata;
  logic [W-1:0]            lane_rdata;
  logic [W-1:0]            rd_word_c;

  logic                    vld_p0;
  logic                    vld_p1;
  logic [W-1:0]            data_p0;
  logic [W-1:0]            data_p1;
  logic                    out_vld_c;
  logic [W-1:0]            out_data_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RESET_STATE;
      sweep_addr <= '0;
    end else begin
      state <= state_next;
      if (state == ST_CLEAR) begin
        sweep_addr <= sweep_addr + 1'b1;
      end
    end
  end

  // clear_req is only looked at in IDLE, so a running sweep is never extended.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (clear_req) state_next = ST_CLEAR;
      ST_CLEAR: if (sweep_addr == LAST_ADDR) state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state == ST_CLEAR);
    rd_accept  = read_req && !busy;
    wr_accept  = write_req && !busy;
    lane_we    = '0;
    lane_waddr = write_addr;
    lane_wdata = write_data;
    if (busy) begin
      lane_we    = '1;
      lane_waddr = sweep_addr;
      lane_wdata = '0;
    end else if (wr_accept) begin
      lane_we = write_lane_en;
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    ram_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_lane (
      .clk   (clk),
      .we    (lane_we[k]),
      .waddr (lane_waddr),
      .wdata (lane_wdata[k*DATA_WIDTH +: DATA_WIDTH]),
      .raddr (read_addr),
      .rdata (lane_rdata[k*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  // Write-first: a same-edge write to the read address is folded into the read.
  always_comb begin
    wr_hit    = wr_accept && (write_addr == read_addr);
    rd_word_c = wr_hit ? merge_lanes(lane_rdata, write_data, write_lane_en) : lane_rdata;
  end

  // ---- stage p0: word captured at the accept edge ----
  // ---- stage p1: one further register for READ_LATENCY=3 ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
      read_valid <= 1'b0;
      read_data  <= '0;
    end else begin
      vld_p0     <= rd_accept;
      vld_p1     <= vld_p0;
      read_valid <= out_vld_c;
      if (out_vld_c) begin
        read_data <= out_data_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rd_accept) begin
      data_p0 <= rd_word_c;
    end
    if (vld_p0) begin
      data_p1 <= data_p0;
    end
  end

  // ---- output stage: tap chosen so read_valid rises READ_LATENCY cycles after accept ----
  always_comb begin
    case (READ_LATENCY)
      1: begin
        out_vld_c  = rd_accept;
        out_data_c = rd_word_c;
      end
      2: begin
        out_vld_c  = vld_p0;
        out_data_c = data_p0;
      end
      default: begin
        out_vld_c  = vld_p1;
        out_data_c = data_p1;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_banked.sv
// Bench for ram_banked: two instances (read latency 1 and 3) on shared inputs,
// checked every cycle against a word-level model plus directed literal checks.
module tb_ram_banked;

  localparam int DW = 8;
  localparam int NL = 4;
  localparam int AW = 12;
  localparam int WW = DW * NL;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          read_req = 1'b0;
  logic [AW-1:0] read_addr = '0;
  logic          write_req = 1'b0;
  logic [AW-1:0] write_addr = '0;
  logic [WW-1:0] write_data = '0;
  logic [NL-1:0] write_lane_en = '0;
  logic          clear_req = 1'b0;

  logic [WW-1:0] rd1, rd3;
  logic          rv1, rv3, busy1, busy3;

  int n_cmp = 0;
  int n_fail = 0;
  int tcyc = 0;
  bit chk_en = 1'b0;

  ram_banked #(.DATA_WIDTH(DW), .NUM_LANES(NL), .ADDR_WIDTH(AW),
               .READ_LATENCY(1), .CLEAR_ON_RESET(1)) dut1 (
    .clk(clk), .reset(reset), .read_req(read_req), .read_addr(read_addr),
    .read_data(rd1), .read_valid(rv1), .write_req(write_req),
    .write_addr(write_addr), .write_data(write_data),
    .write_lane_en(write_lane_en), .clear_req(clear_req), .busy(busy1));

  ram_banked #(.DATA_WIDTH(DW), .NUM_LANES(NL), .ADDR_WIDTH(AW),
               .READ_LATENCY(3), .CLEAR_ON_RESET(1)) dut3 (
    .clk(clk), .reset(reset), .read_req(read_req), .read_addr(read_addr),
    .read_data(rd3), .read_valid(rv3), .write_req(write_req),
    .write_addr(write_addr), .write_data(write_data),
    .write_lane_en(write_lane_en), .clear_req(clear_req), .busy(busy3));

  always #5 clk = ~clk;
  always @(posedge clk) tcyc <= tcyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Word-level model: array of words, a count of sweep cycles left,
  // and per-latency queues of (due cycle, word) for accepted reads.
  typedef struct {
    int          due;
    logic [31:0] data;
  } rd_t;

  logic [31:0] mem_m [DEPTH];
  rd_t         q1[$];
  rd_t         q3[$];
  int          clear_left = DEPTH;
  int          mcyc = 0;
  logic        exp_v1 = 1'b0, exp_v3 = 1'b0;
  logic [31:0] exp_d1 = '0, exp_d3 = '0;

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        q1.delete();
        q3.delete();
        clear_left = DEPTH;
        for (int a = 0; a < DEPTH; a++) mem_m[a] = '0;
        exp_v1 = 1'b0; exp_v3 = 1'b0;
        exp_d1 = '0;   exp_d3 = '0;
      end else begin
        mcyc++;
        if (clear_left > 0) begin
          clear_left--;
        end else begin
          if (write_req)
            for (int k = 0; k < NL; k++)
              if (write_lane_en[k]) mem_m[write_addr][k*DW +: DW] = write_data[k*DW +: DW];
          if (read_req) begin
            q1.push_back('{due: mcyc,     data: mem_m[read_addr]});
            q3.push_back('{due: mcyc + 2, data: mem_m[read_addr]});
          end
          if (clear_req) begin
            clear_left = DEPTH;
            for (int a = 0; a < DEPTH; a++) mem_m[a] = '0;
          end
        end
        exp_v1 = 1'b0;
        if (q1.size() > 0 && q1[0].due == mcyc) begin
          exp_v1 = 1'b1; exp_d1 = q1[0].data; void'(q1.pop_front());
        end
        exp_v3 = 1'b0;
        if (q3.size() > 0 && q3[0].due == mcyc) begin
          exp_v3 = 1'b1; exp_d3 = q3[0].data; void'(q3.pop_front());
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("busy1", {31'b0, busy1}, {31'b0, clear_left > 0});
        check("busy3", {31'b0, busy3}, {31'b0, clear_left > 0});
        check("valid1", {31'b0, rv1}, {31'b0, exp_v1});
        check("valid3", {31'b0, rv3}, {31'b0, exp_v3});
        check("data1", rd1, exp_d1);
        check("data3", rd3, exp_d3);
      end
    end
  end

  bit          log_en = 1'b0;
  int          log_cyc[$];
  logic [31:0] log_dat[$];

  initial begin
    forever begin
      @(negedge clk);
      if (log_en && rv3) begin
        log_cyc.push_back(tcyc);
        log_dat.push_back(rd3);
      end
    end
  end

  task automatic drive(input bit re, input logic [AW-1:0] ra, input bit we,
                       input logic [AW-1:0] wa, input logic [31:0] wd,
                       input logic [NL-1:0] wen, input bit clr);
    read_req = re; read_addr = ra;
    write_req = we; write_addr = wa; write_data = wd; write_lane_en = wen;
    clear_req = clr;
    @(posedge clk); #1;
    read_req = 1'b0; write_req = 1'b0; clear_req = 1'b0; write_lane_en = '0;
  endtask

  task automatic xfer_check(input string name, input logic [AW-1:0] ra, input bit we,
                            input logic [AW-1:0] wa, input logic [31:0] wd,
                            input logic [NL-1:0] wen, input logic [31:0] exp);
    drive(1'b1, ra, we, wa, wd, wen, 1'b0);
    check({name, "_v1"}, {31'b0, rv1}, 32'd1);
    check({name, "_d1"}, rd1, exp);
    repeat (2) begin @(posedge clk); #1; end
    check({name, "_v3"}, {31'b0, rv3}, 32'd1);
    check({name, "_d3"}, rd3, exp);
  endtask

  // Counts busy cycles from now; optionally pokes clear/write/read at busy
  // cycle inject_at, or asserts reset at busy cycle reset_at and returns.
  task automatic count_busy(input int inject_at, input int reset_at, output int cnt);
    cnt = 0;
    for (int guard = 0; guard < 5000; guard++) begin
      @(negedge clk);
      if (!busy1) return;
      cnt++;
      if (cnt == inject_at) begin
        clear_req = 1'b1; write_req = 1'b1; write_addr = 12'h040;
        write_data = 32'h12345678; write_lane_en = 4'hF;
        read_req = 1'b1; read_addr = 12'h010;
      end
      if (cnt == inject_at + 1) begin
        clear_req = 1'b0; write_req = 1'b0; read_req = 1'b0; write_lane_en = '0;
      end
      if (cnt == reset_at) begin
        #2 reset = 1'b1;
        #1;
        check("midrst_valid1", {31'b0, rv1}, 32'd0);
        check("midrst_data1", rd1, 32'd0);
        check("midrst_data3", rd3, 32'd0);
        check("midrst_busy1", {31'b0, busy1}, 32'd1);
        return;
      end
    end
  endtask

  int cnt;
  int first_acc;

  initial begin
    #1 reset = 1'b1;
    #1 chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy1}, 32'd1);
    check("rst_valid", {31'b0, rv1}, 32'd0);
    check("rst_data", rd1, 32'd0);
    reset = 1'b0;
    count_busy(-1, -1, cnt);
    check("init_sweep_len", cnt, 32'd4096);
    @(posedge clk); #1;

    xfer_check("rd_0", 12'h000, 1'b0, '0, '0, '0, 32'h0);
    xfer_check("rd_fff", 12'hFFF, 1'b0, '0, '0, '0, 32'h0);

    drive(1'b0, '0, 1'b1, 12'h010, 32'hDEADBEEF, 4'b1111, 1'b0);
    drive(1'b0, '0, 1'b1, 12'h010, 32'h000000AA, 4'b0001, 1'b0);
    xfer_check("lane_merge", 12'h010, 1'b0, '0, '0, '0, 32'hDEADBEAA);
    drive(1'b0, '0, 1'b1, 12'h010, 32'h12345678, 4'b0000, 1'b0);
    xfer_check("lane_en_zero", 12'h010, 1'b0, '0, '0, '0, 32'hDEADBEAA);

    for (int i = 0; i < 8; i++)
      drive(1'b0, '0, 1'b1, AW'(i), 32'hA0A00000 + i, 4'hF, 1'b0);
    log_cyc.delete(); log_dat.delete();
    log_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      read_req = 1'b1; read_addr = AW'(i);
      @(posedge clk); #1;
      if (i == 0) first_acc = tcyc;
    end
    read_req = 1'b0;
    repeat (6) @(posedge clk);
    #1 log_en = 1'b0;
    check("burst_count", log_cyc.size(), 32'd8);
    for (int i = 0; i < 8 && i < log_cyc.size(); i++) begin
      check("burst_cycle", log_cyc[i], first_acc + 2 + i);
      check("burst_data", log_dat[i], 32'hA0A00000 + i);
    end

    drive(1'b0, '0, 1'b1, 12'h020, 32'hFFFFFFFF, 4'b1111, 1'b0);
    xfer_check("wr_first", 12'h020, 1'b1, 12'h020, 32'h11223344, 4'b0011, 32'hFFFF3344);
    drive(1'b1, 12'h020, 1'b0, '0, '0, '0, 1'b0);
    drive(1'b0, '0, 1'b1, 12'h020, 32'h0, 4'hF, 1'b0);
    repeat (3) @(posedge clk);
    #1 check("inflight_keep3", rd3, 32'hFFFF3344);
    xfer_check("after_overwrite", 12'h020, 1'b0, '0, '0, '0, 32'h0);

    drive(1'b1, 12'h010, 1'b0, '0, '0, '0, 1'b1);
    check("preclear_rd1", rd1, 32'hDEADBEAA);
    count_busy(100, -1, cnt);
    check("req_sweep_len", cnt, 32'd4096);
    @(posedge clk); #1;
    xfer_check("dropped_wr", 12'h040, 1'b0, '0, '0, '0, 32'h0);
    xfer_check("cleared_010", 12'h010, 1'b0, '0, '0, '0, 32'h0);

    drive(1'b0, '0, 1'b1, 12'h050, 32'hCAFEF00D, 4'hF, 1'b0);
    drive(1'b1, 12'h050, 1'b0, '0, '0, '0, 1'b1);
    check("pre_sweep_rd1", rd1, 32'hCAFEF00D);
    count_busy(-1, 2001, cnt);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    count_busy(-1, -1, cnt);
    check("restart_sweep_len", cnt, 32'd4096);
    @(posedge clk); #1;
    xfer_check("post_rst_050", 12'h050, 1'b0, '0, '0, '0, 32'h0);

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

endmodule
